e1_ts_demux: RTL



---
 rtl/e1_pkg.sv | 19 +
 rtl/e1_bitpos_cnt.sv | 53 +++++
 rtl/e1_ts_demux.sv | 133 +++++++++++++
 3 files changed

// File: rtl/e1_pkg.sv
// ---------------------------------------------------------------------------
// e1_pkg
//   Shared E1 framing constants and types used by the receive-side blocks.
//   E1_TS_PER_FRAME   : timeslots per 256-bit frame
//   E1_BITS_PER_FRAME : bits per frame
//   E1_FAS            : frame alignment word carried in TS0 of even frames
//   E1_MFAS           : multiframe position of the frame carrying the MF start
//   e1_ts_t           : timeslot index 0..31
// ---------------------------------------------------------------------------
package e1_pkg;

  localparam int unsigned E1_TS_PER_FRAME   = 32;
  localparam int unsigned E1_BITS_PER_FRAME = 256;
  localparam logic [7:0]  E1_FAS            = 8'h1B;
  localparam logic [3:0]  E1_MFAS           = 4'b0000;

  typedef logic [$clog2(E1_TS_PER_FRAME)-1:0] e1_ts_t;

endpackage

// File: rtl/e1_bitpos_cnt.sv
// ---------------------------------------------------------------------------
// e1_bitpos_cnt
//   Bit position counter within an E1 frame, with realignment on an
//   off-position frame_start.
//   clk_i         : system clock
//   rst_ni        : synchronous active-low reset
//   bit_en_i      : one strobe per E1 bit period
//   frame_start_i : the bit presented with this strobe is bit 7 of TS0
//   bitpos_o      : position (0..255) of the bit presented with bit_en_i
//   wrap_o        : frame boundary crossed on this strobe (natural or forced)
//   slip_o        : frame_start_i arrived off position 0 on this strobe
// ---------------------------------------------------------------------------
module e1_bitpos_cnt
  import e1_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       bit_en_i,
  input  logic       frame_start_i,
  output logic [7:0] bitpos_o,
  output logic       wrap_o,
  output logic       slip_o
);

  logic [7:0] bitpos_q, bitpos_d;
  logic       realign;
  logic       at_last;

  always_comb begin
    at_last  = (bitpos_q == 8'(E1_BITS_PER_FRAME - 1));
    realign  = bit_en_i && frame_start_i && (bitpos_q != '0);
    bitpos_d = bitpos_q;
    // The realigning bit itself occupies position 0, so the next bit is 1.
    if (realign) begin
      bitpos_d = 8'd1;
    end else if (bit_en_i) begin
      bitpos_d = bitpos_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bitpos_q <= '0;
    end else begin
      bitpos_q <= bitpos_d;
    end
  end

  assign bitpos_o = bitpos_q;
  assign wrap_o   = bit_en_i && (at_last || realign);
  assign slip_o   = realign;

endmodule

// File: rtl/e1_ts_demux.sv
// ---------------------------------------------------------------------------
// e1_ts_demux
//   Receive-side E1 timeslot extractor. Deserialises the bitstream into
//   32 timeslot bytes per frame, tags each with timeslot and multiframe
//   position, and releases bytes only while frame alignment holds.
//   clk, rst_n   : clock, synchronous active-low reset
//   bit_en, din  : bit strobe and serial data (MSB first)
//   frame_start  : with bit_en, din carries bit 7 of TS0
//   mf_start     : with frame_start, this frame is multiframe frame 0
//   sync         : frame alignment held
//   syncmulti    : multiframe alignment held
//   ts_data      : completed timeslot byte
//   ts_num       : timeslot index of ts_data
//   frame_num    : multiframe frame index of ts_data (0 without syncmulti)
//   ts_valid     : one-cycle pulse, byte outputs valid
//   fas_err      : one-cycle pulse with ts_valid, even-frame TS0 mismatch
//   slip         : one-cycle pulse, frame_start off expected position
//   slip_cnt     : saturating slip count
// ---------------------------------------------------------------------------
module e1_ts_demux
  import e1_pkg::*;
#(
  parameter logic [7:0]  FAS_WORD  = E1_FAS,
  parameter int unsigned MF_FRAMES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_en,
  input  logic       din,
  input  logic       frame_start,
  input  logic       mf_start,
  input  logic       sync,
  input  logic       syncmulti,
  output logic [7:0] ts_data,
  output logic [4:0] ts_num,
  output logic [3:0] frame_num,
  output logic       ts_valid,
  output logic       fas_err,
  output logic       slip,
  output logic [7:0] slip_cnt
);

  logic [7:0] bitpos;
  logic       wrap;
  logic       slip_now;

  e1_bitpos_cnt u_bitpos (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .bit_en_i      (bit_en),
    .frame_start_i (frame_start),
    .bitpos_o      (bitpos),
    .wrap_o        (wrap),
    .slip_o        (slip_now)
  );

  logic [7:0] shreg_q, shreg_d;
  logic       fpar_q, fpar_d;
  logic [3:0] mfc_q, mfc_d;
  logic [7:0] slip_cnt_q, slip_cnt_d;
  logic [7:0] ts_data_q;
  e1_ts_t     ts_num_q;
  logic [3:0] frame_num_q;
  logic       ts_valid_q, fas_err_q, slip_q;

  logic       byte_done, emit, fas_bad, mf_clr;

  always_comb begin
    shreg_d   = {shreg_q[6:0], din};
    // A realign on a byte boundary discards that byte.
    byte_done = bit_en && (bitpos[2:0] == 3'd7) && !slip_now;
    emit      = byte_done && sync;
    fas_bad   = emit && (bitpos[7:3] == '0) && !fpar_q &&
                (shreg_d[6:0] != FAS_WORD[6:0]);
    mf_clr    = bit_en && frame_start && mf_start;

    // mf_start takes priority over a coincident (forced) frame wrap.
    fpar_d = fpar_q;
    mfc_d  = mfc_q;
    if (mf_clr) begin
      fpar_d = 1'b0;
      mfc_d  = E1_MFAS;
    end else if (wrap) begin
      fpar_d = ~fpar_q;
      mfc_d  = (mfc_q == 4'(MF_FRAMES - 1)) ? '0 : mfc_q + 4'd1;
    end

    slip_cnt_d = slip_cnt_q;
    if (slip_now && (slip_cnt_q != '1)) begin
      slip_cnt_d = slip_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q     <= '0;
      fpar_q      <= 1'b0;
      mfc_q       <= '0;
      slip_cnt_q  <= '0;
      ts_data_q   <= '0;
      ts_num_q    <= '0;
      frame_num_q <= '0;
      ts_valid_q  <= 1'b0;
      fas_err_q   <= 1'b0;
      slip_q      <= 1'b0;
    end else begin
      if (bit_en) begin
        shreg_q <= shreg_d;
      end
      fpar_q     <= fpar_d;
      mfc_q      <= mfc_d;
      slip_cnt_q <= slip_cnt_d;
      ts_valid_q <= emit;
      fas_err_q  <= fas_bad;
      slip_q     <= slip_now;
      // Byte outputs hold their last released value while out of sync.
      if (emit) begin
        ts_data_q   <= shreg_d;
        ts_num_q    <= bitpos[7:3];
        frame_num_q <= syncmulti ? mfc_q : '0;
      end
    end
  end

  assign ts_data   = ts_data_q;
  assign ts_num    = ts_num_q;
  assign frame_num = frame_num_q;
  assign ts_valid  = ts_valid_q;
  assign fas_err   = fas_err_q;
  assign slip      = slip_q;
  assign slip_cnt  = slip_cnt_q;

endmodule
